// File: rtl/palette_lut.sv
`timescale 1ns/1ps
// rtl/palette_lut.sv - runtime-writable colour palette with a 2-stage pixel lookup pipeline
// The frame-stepped brightness fade is built only when PALETTE_FADE_EN is defined.
module palette_lut #(
  parameter int INDEX_W     = 5,
  parameter int COLOR_W     = 12,
  parameter int NUM_PAL     = 2,
  parameter int FADE_FRAMES = 4,
  localparam int PAL_W      = (NUM_PAL > 1) ? $clog2(NUM_PAL) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_start,
  input  logic [PAL_W-1:0]   pal_sel,
  input  logic               pix_valid_in,
  input  logic [INDEX_W-1:0] pix_idx,
  input  logic               wr_en,
  input  logic [PAL_W-1:0]   wr_pal,
  input  logic [INDEX_W-1:0] wr_idx,
  input  logic [COLOR_W-1:0] wr_data,
  input  logic               fade_start,
  input  logic               fade_dir,
  output logic               pix_valid_out,
  output logic [COLOR_W-1:0] pix_out,
  output logic [PAL_W-1:0]   active_pal,
  output logic               fade_busy,
  output logic               fade_done,
  output logic [4:0]         fade_level
);

  localparam int CW    = COLOR_W / 3;
  localparam int DEPTH = 1 << INDEX_W;

  function automatic logic [COLOR_W-1:0] default_entry(input int p, input int i);
    logic [COLOR_W-1:0] v;
    v = '0;
    if (p == 0 && i == 0)  v = COLOR_W'(12'hCEE);
    if (p == 0 && i == 28) v = COLOR_W'(12'h232);
    if (p == 1 && i == 0)  v = COLOR_W'(12'h9CD);
    if (p == 1 && i == 30) v = COLOR_W'(12'h014);
    return v;
  endfunction

  logic [COLOR_W-1:0] r_mem [NUM_PAL][DEPTH];
  logic [PAL_W-1:0]   r_active_pal;
  logic               r_s1_valid;
  logic [COLOR_W-1:0] r_s1_color;
  logic               r_s2_valid;
  logic [COLOR_W-1:0] r_s2_color;
  logic [COLOR_W-1:0] w_s2_color;
  logic               w_wr_ok;
  logic               w_sel_ok;

  assign w_wr_ok  = (int'(wr_pal) < NUM_PAL);
  assign w_sel_ok = (int'(pal_sel) < NUM_PAL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < NUM_PAL; p++) begin
        for (int i = 0; i < DEPTH; i++) begin
          r_mem[p][i] <= default_entry(p, i);
        end
      end
    end else if (wr_en && w_wr_ok) begin
      r_mem[wr_pal][wr_idx] <= wr_data;
    end
  end

  // Palette reads below see the pre-write table, so a same-cycle write is only visible next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active_pal <= '0;
      r_s1_valid   <= 1'b0;
      r_s1_color   <= '0;
      r_s2_valid   <= 1'b0;
      r_s2_color   <= '0;
    end else begin
      if (frame_start && w_sel_ok) r_active_pal <= pal_sel;
      r_s1_valid <= pix_valid_in;
      if (pix_valid_in) r_s1_color <= r_mem[r_active_pal][pix_idx];
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) r_s2_color <= w_s2_color;
    end
  end

  assign pix_valid_out = r_s2_valid;
  assign pix_out       = r_s2_color;
  assign active_pal    = r_active_pal;

`ifdef PALETTE_FADE_EN
  localparam int FC_W = (FADE_FRAMES > 1) ? $clog2(FADE_FRAMES) : 1;

  typedef enum logic {S_IDLE, S_FADING} state_t;

  state_t          r_state;
  logic            r_dir;
  logic [FC_W-1:0] r_cnt;
  logic [4:0]      r_level;
  logic            r_done;

  function automatic logic [CW-1:0] scale(input logic [CW-1:0] c, input logic [4:0] lvl);
    return CW'(({5'b0, c} * {{CW{1'b0}}, lvl}) >> 4);
  endfunction

  // A fade_start always wins over a coincident frame_start, which is then not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_dir   <= 1'b0;
      r_cnt   <= '0;
      r_level <= 5'd16;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (fade_start) begin
        r_dir <= fade_dir;
        r_cnt <= '0;
        if (fade_dir ? (r_level == 5'd16) : (r_level == 5'd0)) begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end else begin
          r_state <= S_FADING;
        end
      end else if (r_state == S_FADING && frame_start) begin
        if (r_cnt == FC_W'(FADE_FRAMES - 1)) begin
          r_cnt   <= '0;
          r_level <= r_dir ? (r_level + 5'd1) : (r_level - 5'd1);
          if (r_dir ? (r_level == 5'd15) : (r_level == 5'd1)) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end else begin
          r_cnt <= r_cnt + FC_W'(1);
        end
      end
    end
  end

  always_comb begin
    w_s2_color = '0;
    for (int ch = 0; ch < 3; ch++) begin
      w_s2_color[ch*CW +: CW] = scale(r_s1_color[ch*CW +: CW], r_level);
    end
  end

  assign fade_level = r_level;
  assign fade_busy  = (r_state == S_FADING);
  assign fade_done  = r_done;
`else
  logic w_unused;

  assign w_unused   = &{1'b0, fade_start, fade_dir};
  assign w_s2_color = r_s1_color;
  assign fade_level = 5'd16;
  assign fade_busy  = 1'b0;
  assign fade_done  = 1'b0;
`endif

endmodule

// File: tb/tb_palette_lut.sv
`timescale 1ns/1ps
// tb/tb_palette_lut.sv - scoreboard bench for palette_lut (fade checks when PALETTE_FADE_EN is defined)
module tb_palette_lut;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_start;
  logic [1:0]  pal_sel;
  logic        pix_valid_in;
  logic [4:0]  pix_idx;
  logic        wr_en;
  logic [1:0]  wr_pal;
  logic [4:0]  wr_idx;
  logic [11:0] wr_data;
  logic        fade_start;
  logic        fade_dir;
  logic        pix_valid_out;
  logic [11:0] pix_out;
  logic [1:0]  active_pal;
  logic        fade_busy;
  logic        fade_done;
  logic [4:0]  fade_level;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_done  = 0;
  logic [11:0] exp_q[$];

  palette_lut #(.INDEX_W(5), .COLOR_W(12), .NUM_PAL(3), .FADE_FRAMES(1)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .pal_sel(pal_sel),
    .pix_valid_in(pix_valid_in), .pix_idx(pix_idx), .wr_en(wr_en), .wr_pal(wr_pal),
    .wr_idx(wr_idx), .wr_data(wr_data), .fade_start(fade_start), .fade_dir(fade_dir),
    .pix_valid_out(pix_valid_out), .pix_out(pix_out), .active_pal(active_pal),
    .fade_busy(fade_busy), .fade_done(fade_done), .fade_level(fade_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [11:0] e;
    if (rst_n === 1'b1 && fade_done === 1'b1) n_done++;
    if (rst_n === 1'b1 && pix_valid_out === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pix_unexpected: got %h expected no output", pix_out);
      end else begin
        e = exp_q.pop_front();
        if (pix_out !== e) begin
          n_fail++;
          $display("FAIL pix_out: got %h expected %h", pix_out, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] idx, input logic [11:0] exp);
    pix_valid_in = 1'b1;
    pix_idx      = idx;
    exp_q.push_back(exp);
  endtask

  task automatic req(input logic [4:0] idx, input logic [11:0] exp);
    issue(idx, exp);
    tick();
    pix_valid_in = 1'b0;
  endtask

  task automatic frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
    chk("drain_pending", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    rst_n = 1'b0; frame_start = 1'b0; pal_sel = 2'd0; pix_valid_in = 1'b0; pix_idx = '0;
    wr_en = 1'b0; wr_pal = '0; wr_idx = '0; wr_data = '0; fade_start = 1'b0; fade_dir = 1'b0;
    tick(); tick();
    chk("rst_pix_out", pix_out, 0);
    chk("rst_valid", pix_valid_out, 0);
    chk("rst_active_pal", active_pal, 0);
    chk("rst_level", fade_level, 16);
    chk("rst_busy", fade_busy, 0);
    chk("rst_done", fade_done, 0);
    rst_n = 1'b1;
    tick();

    // default tables and 2-edge latency
    issue(0, 12'hCEE);
    tick();
    pix_valid_in = 1'b0;
    chk("lat_edge1_valid", pix_valid_out, 0);
    tick();
    chk("lat_edge2_valid", pix_valid_out, 1);
    req(28, 12'h232);
    req(1, 12'h000);
    drain();

    // mid-frame pal_sel change has no effect
    pal_sel = 2'd1;
    req(0, 12'hCEE);
    chk("pal_no_frame", active_pal, 0);
    // request coincident with frame_start uses old palette
    frame_start = 1'b1;
    issue(0, 12'hCEE);
    tick();
    frame_start = 1'b0; pix_valid_in = 1'b0;
    chk("pal_switch", active_pal, 1);
    req(0, 12'h9CD);
    req(30, 12'h014);
    pal_sel = 2'd3;
    frame();
    chk("pal_out_of_range", active_pal, 1);
    req(0, 12'h9CD);
    pal_sel = 2'd2;
    frame();
    chk("pal_two", active_pal, 2);
    req(0, 12'h000);
    pal_sel = 2'd0;
    frame();
    drain();

    // write/read collision returns old value, next cycle sees new
    wr_en = 1'b1; wr_pal = 2'd0; wr_idx = 5'd3; wr_data = 12'hABC;
    issue(3, 12'h000);
    tick();
    wr_en = 1'b0;
    req(3, 12'hABC);
    wr_en = 1'b1; wr_pal = 2'd3; wr_idx = 5'd5; wr_data = 12'h555;
    tick();
    wr_pal = 2'd0; wr_idx = 5'd0; wr_data = 12'h0FF;
    tick();
    wr_idx = 5'd7; wr_data = 12'hFFF;
    tick();
    wr_en = 1'b0;
    req(5, 12'h000);
    req(0, 12'h0FF);
    req(7, 12'hFFF);
    drain();

`ifdef PALETTE_FADE_EN
    d0 = n_done;
    fade_dir = 1'b0; fade_start = 1'b1;
    tick();
    fade_start = 1'b0;
    chk("fade_busy_start", fade_busy, 1);
    chk("fade_level_start", fade_level, 16);
    for (int k = 1; k <= 16; k++) begin
      frame();
      chk("fade_down_level", fade_level, 16 - k);
      if (k == 8) begin
        req(7, 12'h777);
        drain();
      end
    end
    chk("fade_done_pulse", fade_done, 1);
    chk("fade_busy_end", fade_busy, 0);
    req(7, 12'h000);
    drain();
    chk("fade_done_count", n_done - d0, 1);

    fade_dir = 1'b0; fade_start = 1'b1;
    tick();
    fade_start = 1'b0;
    chk("fade_reached_done", fade_done, 1);
    chk("fade_reached_busy", fade_busy, 0);
    tick();
    chk("fade_reached_done_low", fade_done, 0);

    fade_dir = 1'b1; fade_start = 1'b1;
    tick();
    fade_start = 1'b0;
    for (int k = 0; k < 16; k++) frame();
    chk("fade_up_level", fade_level, 16);
    fade_dir = 1'b0; fade_start = 1'b1;
    tick();
    fade_start = 1'b0;
    for (int k = 0; k < 6; k++) frame();
    chk("rev_level10", fade_level, 10);
    d0 = n_done;
    fade_dir = 1'b1; fade_start = 1'b1; frame_start = 1'b1;
    tick();
    fade_start = 1'b0; frame_start = 1'b0;
    chk("rev_coincident_level", fade_level, 10);
    chk("rev_busy", fade_busy, 1);
    frame(); frame();
    chk("rev_level12", fade_level, 12);
    req(7, 12'hBBB);
    drain();
    for (int k = 0; k < 4; k++) frame();
    chk("rev_level16", fade_level, 16);
    chk("rev_busy_end", fade_busy, 0);
    chk("rev_done_count", n_done - d0, 1);
`else
    fade_dir = 1'b0; fade_start = 1'b1;
    tick();
    fade_start = 1'b0;
    frame();
    chk("nofade_busy", fade_busy, 0);
    chk("nofade_level", fade_level, 16);
    chk("nofade_done", fade_done, 0);
`endif

    // asynchronous reset mid-fade and mid-stream
    pal_sel = 2'd1;
    frame();
    fade_dir = 1'b0; fade_start = 1'b1;
    tick();
    fade_start = 1'b0;
    frame(); frame(); frame();
    pix_valid_in = 1'b1; pix_idx = 5'd0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    pix_valid_in = 1'b0;
    exp_q.delete();
    #1;
    chk("arst_pix_out", pix_out, 0);
    chk("arst_valid", pix_valid_out, 0);
    chk("arst_active_pal", active_pal, 0);
    chk("arst_level", fade_level, 16);
    chk("arst_busy", fade_busy, 0);
    chk("arst_done", fade_done, 0);
    tick(); tick();
    rst_n = 1'b1;
    pal_sel = 2'd0;
    tick();
    req(0, 12'hCEE);
    req(3, 12'h000);
    req(7, 12'h000);
    drain();
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/palette_lut.md
# palette_lut

Parametrised, runtime-writable colour palette for the VGA pixel path. It is the successor to the fixed background/menu index decoders. Holds NUM_PAL palettes of 2^INDEX_W entries each and maps a pixel index to a COLOR_W-bit RGB value through a 2-stage registered pipeline. Palette switching is deferred to frame boundaries, and an optional frame-stepped fade scales the output brightness. It sits between the sprite/background index fetch and the VGA output register.

## Interface
- INDEX_W, 5, pixel index width; each palette has 2^INDEX_W entries.
- COLOR_W, 12, colour width; must be a multiple of 3 (CW = COLOR_W/3 bits per channel).
- NUM_PAL, 2, number of palettes; PAL_W = max(1, $clog2(NUM_PAL)).
- FADE_FRAMES, 4, frame_start pulses per fade step (≥1).

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous reset, active low
- frame_start  in  1  one-cycle pulse at start of frame (vsync edge)
- pal_sel  in  PAL_W  requested palette, sampled on frame_start
- pix_valid_in  in  1  pixel request valid
- pix_idx  in  INDEX_W  pixel palette index
- wr_en  in  1  palette entry write strobe
- wr_pal  in  PAL_W  palette written
- wr_idx  in  INDEX_W  entry written
- wr_data  in  COLOR_W  new colour
- fade_start  in  1  one-cycle pulse starting a fade
- fade_dir  in  1  0 = fade to black, 1 = fade to full
- pix_valid_out  out  1  pix_out valid
- pix_out  out  COLOR_W  resolved, faded colour
- active_pal  out  PAL_W  palette currently used for lookups
- fade_busy  out  1  fade in progress
- fade_done  out  1  one-cycle pulse when a fade reaches its end level
- fade_level  out  5  current brightness, 0..16

## Operation
- Storage: NUM_PAL × 2^INDEX_W registers. Reset loads the built-in default tables. Palette 0 is the background set: entry 0 = 12'hCEE, entry 28 = 12'h232. Palette 1 is the menu set: entry 0 = 12'h9CD, entry 30 = 12'h014. Entries with no table value reset to 0.
- Write: when wr_en=1 and wr_pal<NUM_PAL, entry [wr_pal][wr_idx] = wr_data at the clock edge. If wr_pal≥NUM_PAL, the write is dropped.
- Palette switch: on frame_start, active_pal ← pal_sel if pal_sel<NUM_PAL; otherwise it is unchanged. Mid-frame changes to pal_sel have no effect.
- Stage 1: if pix_valid_in=1, register the colour at mem[active_pal][pix_idx] together with the valid bit. If pix_valid_in=0, the colour register holds and the valid bit is 0.
- Stage 2: split the colour into 3 channels. For each channel, c_out = (c × fade_level) >> 4, computed at CW+5 bits and truncated to CW. Level 16 is identity and level 0 is black.
- Fade FSM, IDLE/FADING:
  - In IDLE, fade_start sets dir, clears the frame counter and enters FADING.
  - In FADING, each frame_start increments the counter. When the counter reaches FADE_FRAMES-1 it wraps to 0, and fade_level steps by ±1.
  - When the level reaches 0 (dir 0) or 16 (dir 1), the FSM pulses fade_done and returns to IDLE.
  - fade_start in FADING restarts from the current level with the new dir and clears the counter.
  - fade_start toward a level already reached pulses fade_done next cycle and stays IDLE.
  - fade_start coincident with frame_start: that frame_start is not counted.
- Reset values: pix_out=0, pix_valid_out=0, active_pal=0, fade_level=16, fade_busy=0, fade_done=0, FSM=IDLE.

## Timing
- Lookup latency is 2 cycles: request at edge t yields pix_out/pix_valid_out after edge t+2. Throughput is 1 pixel per cycle with no stalls.
- Read and write of the same entry in the same cycle: the read returns the old value. The new value is visible to reads issued from the next cycle.
- active_pal changes at the frame_start edge. A request in the same cycle as frame_start uses the old palette.
- fade_level changes at the frame_start edge. Pixels already in stage 2 use the level at their stage-2 edge.
- fade_busy is 1 exactly while FADING. fade_done rises on the same edge fade_busy falls.
- Asynchronous reset mid-operation clears the pipeline, restores the default tables, and aborts any fade.

## Configuration
- PALETTE_FADE_EN defined: fade FSM, counter and stage-2 multiply are present, as described above.
- Not defined: fade_level is tied to 16, fade_busy=0, fade_done=0, and fade_start/fade_dir are ignored. Stage 2 is a plain register, so latency stays 2 cycles.

## Test plan
- Reset, then request idx 0 with pal_sel=0 → pix_out=12'hCEE two cycles later; after pal_sel=1 plus frame_start, the same request returns 12'h9CD.
- Write [0][3]=12'hABC while reading idx 3 in the same cycle → first read returns the default value, the next cycle's read returns 12'hABC.
- Change pal_sel to 1 with no frame_start → output stays palette 0; pal_sel=3 (out of range) on frame_start → active_pal unchanged.
- With PALETTE_FADE_EN and FADE_FRAMES=1, fade_start dir=0, then 16 frame_starts → level goes 16→0, 12'hFFF becomes 12'h777 at level 8 and 0 at level 0, fade_done pulses once, fade_busy drops.
- Issue fade_start dir=1 during a dir=0 fade at level 10 → level climbs from 10 to 16, a single fade_done pulse.
- Assert rst_n low mid-fade and mid-stream → all outputs 0 except fade_level=16, written entries restored to defaults.
